// File: rtl/shift_arb_if.sv
// Bundle of every handshake/bus signal around shift_arb.
//   r0_* / r1_* : request channels (valid/ready plus operand, amount, mode)
//   shf_*       : combinational drive to and return from the shared shifter
//   rsp_*       : registered response channel (valid/ready plus data, flags, id, err)
// The slave modport is the arbiter's view; master is the surrounding logic.
interface shift_arb_if #(
    parameter int DW = 16,
    parameter int SW = 4,
    parameter int FW = 3
);
    logic          r0_valid;
    logic          r0_ready;
    logic [DW-1:0] r0_data;
    logic [SW-1:0] r0_amt;
    logic [1:0]    r0_mode;

    logic          r1_valid;
    logic          r1_ready;
    logic [DW-1:0] r1_data;
    logic [SW-1:0] r1_amt;
    logic [1:0]    r1_mode;

    logic [DW-1:0] shf_in;
    logic [SW-1:0] shf_val;
    logic [1:0]    shf_mode;
    logic [DW-1:0] shf_out;
    logic [FW-1:0] shf_flag;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [FW-1:0] rsp_flag;
    logic          rsp_id;
    logic          rsp_err;

    modport slave (
        input  r0_valid, r0_data, r0_amt, r0_mode,
        output r0_ready,
        input  r1_valid, r1_data, r1_amt, r1_mode,
        output r1_ready,
        output shf_in, shf_val, shf_mode,
        input  shf_out, shf_flag,
        output rsp_valid, rsp_data, rsp_flag, rsp_id, rsp_err,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_data, r0_amt, r0_mode,
        input  r0_ready,
        output r1_valid, r1_data, r1_amt, r1_mode,
        input  r1_ready,
        input  shf_in, shf_val, shf_mode,
        output shf_out, shf_flag,
        input  rsp_valid, rsp_data, rsp_flag, rsp_id, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/shift_arb.sv
// Round-robin front-end for the single shared shifter.
// Picks one of two requesters per cycle, drives the shifter inputs from the
// winner, and captures result/flags into a one-entry response register.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : shift_arb_if.slave (request, shifter and response channels)
module shift_arb #(
    parameter int DW = 16,
    parameter int SW = 4,
    parameter int FW = 3
) (
    input  logic        clk,
    input  logic        rst,
    shift_arb_if.slave  bus
);
    localparam logic [1:0] MODE_RSVD = 2'b11;

    logic          prio_q;      // 0: r0 wins a tie, 1: r1 wins a tie
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic [FW-1:0] rsp_flag_q;
    logic          rsp_id_q;
    logic          rsp_err_q;

    logic          slot_free;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic [DW-1:0] sel_data;
    logic [SW-1:0] sel_amt;
    logic [1:0]    sel_mode;
    logic          sel_rsvd;

    always_comb begin
        slot_free = ~rsp_valid_q | bus.rsp_ready;
        grant0    = bus.r0_valid & (~bus.r1_valid | ~prio_q);
        grant1    = bus.r1_valid & (~bus.r0_valid |  prio_q);

        // Without a grant r0's fields are forwarded, keeping the shifter deterministic.
        sel_data = bus.r0_data;
        sel_amt  = bus.r0_amt;
        sel_mode = bus.r0_mode;
        if (grant1) begin
            sel_data = bus.r1_data;
            sel_amt  = bus.r1_amt;
            sel_mode = bus.r1_mode;
        end
        sel_rsvd = (sel_mode == MODE_RSVD);

        bus.r0_ready = grant0 & slot_free & ~rst;
        bus.r1_ready = grant1 & slot_free & ~rst;
        accept       = (bus.r0_valid & bus.r0_ready) | (bus.r1_valid & bus.r1_ready);

        bus.shf_in   = sel_data;
        bus.shf_val  = sel_amt;
        bus.shf_mode = sel_mode;

        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_flag  = rsp_flag_q;
        bus.rsp_id    = rsp_id_q;
        bus.rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            // Accept wins over drain: the slot is refilled on the same edge.
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant1;
            prio_q      <= ~grant1;
            if (sel_rsvd) begin
                // Reserved mode bypasses the shifter: operand returned untouched.
                rsp_data_q <= sel_data;
                rsp_flag_q <= '0;
                rsp_err_q  <= 1'b1;
            end else begin
                rsp_data_q <= bus.shf_out;
                rsp_flag_q <= bus.shf_flag;
                rsp_err_q  <= 1'b0;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_arb.sv
// Scoreboard bench for shift_arb with a behavioural shifter model.
module tb_shift_arb;
    localparam int DW = 16;
    localparam int SW = 4;
    localparam int FW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [FW-1:0] flag;
        logic          id;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_arb_if #(.DW(DW), .SW(SW), .FW(FW)) bus ();

    shift_arb #(.DW(DW), .SW(SW), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    function automatic logic [FW-1:0] flag_fn(input logic [DW-1:0] r);
        return {(r == '0), r[DW-1], ^r};
    endfunction

    // Shared shifter model; reserved mode returns junk that the DUT must ignore.
    logic [2*DW-1:0] ror_tmp;
    always_comb begin
        ror_tmp      = {bus.shf_in, bus.shf_in} >> bus.shf_val;
        bus.shf_out  = 16'hDEAD;
        bus.shf_flag = 3'b111;
        case (bus.shf_mode)
            2'b00: bus.shf_out = bus.shf_in << bus.shf_val;
            2'b01: bus.shf_out = $unsigned($signed(bus.shf_in) >>> bus.shf_val);
            2'b10: bus.shf_out = ror_tmp[DW-1:0];
            default: bus.shf_out = 16'hDEAD;
        endcase
        if (bus.shf_mode != 2'b11) bus.shf_flag = flag_fn(bus.shf_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic id, input logic err);
        rsp_t e;
        e.data = d;
        e.flag = err ? '0 : flag_fn(d);
        e.id   = id;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [DW-1:0] d,
                           input logic [SW-1:0] a, input logic [1:0] m);
        if (id == 1'b0) begin
            bus.r0_valid = v; bus.r0_data = d; bus.r0_amt = a; bus.r0_mode = m;
        end else begin
            bus.r1_valid = v; bus.r1_data = d; bus.r1_amt = a; bus.r1_mode = m;
        end
    endtask

    // Present one request, wait (bounded) for its ready, drop valid after the edge.
    task automatic req(input logic id, input logic [DW-1:0] d,
                       input logic [SW-1:0] a, input logic [1:0] m);
        bit got = 0;
        set_req(id, 1'b1, d, a, m);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && bus.r0_ready) || (id == 1'b1 && bus.r1_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk_cnt++;
            $display("FAIL req_timeout: requester %0d never saw ready", id);
        end
        @(posedge clk);
        #1;
        if (id == 1'b0) bus.r0_valid = 1'b0;
        else            bus.r1_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_rsp: data %h id %0d, none expected", bus.rsp_data, bus.rsp_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                chk("rsp_flag", 32'(bus.rsp_flag), 32'(mon_e.flag));
                chk("rsp_id",   32'(bus.rsp_id),   32'(mon_e.id));
                chk("rsp_err",  32'(bus.rsp_err),  32'(mon_e.err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_req(0, 1'b1, 16'h0000, 4'd0, 2'b00);
        set_req(1, 1'b0, 16'h0000, 4'd0, 2'b00);
        bus.rsp_ready = 1'b1;
        #12;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_data",  32'(bus.rsp_data),  0);
        chk("reset_rsp_flag",  32'(bus.rsp_flag),  0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   0);
        chk("reset_r0_ready",  32'(bus.r0_ready),  0);
        bus.r0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // r0 alone, SLL
        push(16'h2340, 0, 0);
        req(0, 16'h1234, 4'd4, 2'b00);

        // r1 alone, ROR back-to-back
        push(16'h1234, 1, 0); push(16'h4123, 1, 0);
        push(16'h3412, 1, 0); push(16'h2341, 1, 0);
        req(1, 16'h1234, 4'd0,  2'b10);
        req(1, 16'h1234, 4'd4,  2'b10);
        req(1, 16'h1234, 4'd8,  2'b10);
        req(1, 16'h1234, 4'd12, 2'b10);

        // Both valid: strict alternation starting from r0
        for (int k = 0; k < 2; k++) begin
            push(16'hF000, 0, 0);
            push(16'h01E0, 1, 0);
        end
        set_req(0, 1'b1, 16'h8000, 4'd3, 2'b01);
        set_req(1, 1'b1, 16'h00F0, 4'd1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_r0_ready", 32'(bus.r0_ready), 32'((k % 2) == 0));
            chk("rr_r1_ready", 32'(bus.r1_ready), 32'((k % 2) == 1));
            @(posedge clk);
        end
        #1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;

        // Maximum amount
        push(16'h8000, 0, 0);
        req(0, 16'h0003, 4'd15, 2'b00);
        push(16'hFFFF, 1, 0);
        req(1, 16'h8000, 4'd15, 2'b01);

        // Reserved mode, then a normal request clears err
        push(16'hABCD, 0, 1);
        req(0, 16'hABCD, 4'd5, 2'b11);
        push(16'h00F0, 0, 0);
        req(0, 16'h0F0F, 4'd4, 2'b01);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure, then drain and accept on the same edge
        bus.rsp_ready = 1'b0;
        push(16'h0002, 0, 0);
        req(0, 16'h0001, 4'd1, 2'b00);
        push(16'h000C, 0, 0);
        set_req(0, 1'b1, 16'h0003, 4'd2, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_r0_ready",  32'(bus.r0_ready),  0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_data",  32'(bus.rsp_data),  32'h0002);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_r0_ready", 32'(bus.r0_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_refill_valid", 32'(bus.rsp_valid), 1);
        chk("bp_refill_data",  32'(bus.rsp_data),  32'h000C);
        bus.r0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-transaction drops the held response and the pointer
        bus.rsp_ready = 1'b0;
        req(0, 16'h0004, 4'd2, 2'b00);
        set_req(0, 1'b1, 16'h1111, 4'd0, 2'b00);
        set_req(1, 1'b1, 16'h0001, 4'd1, 2'b10);
        @(negedge clk);
        chk("pre_rst_valid",    32'(bus.rsp_valid), 1);
        chk("pre_rst_r0_ready", 32'(bus.r0_ready),  0);
        chk("pre_rst_r1_ready", 32'(bus.r1_ready),  0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  0);
        chk("rst_r0_ready",  32'(bus.r0_ready),  0);
        chk("rst_r1_ready",  32'(bus.r1_ready),  0);
        exp_q.delete();
        push(16'h1111, 0, 0);
        push(16'h8000, 1, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_r0_ready", 32'(bus.r0_ready), 1);
        chk("post_rst_r1_ready", 32'(bus.r1_ready), 0);
        @(negedge clk);
        chk("post_rst_r1_turn", 32'(bus.r1_ready), 1);
        @(posedge clk);
        #1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL missing_rsp: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
- Arbitration and sequencing front-end for the single shared 16-bit shifter (modes SLL/SRA/ROR, 4-bit shift amount, 3-bit flag output).
- Two requesters share the shifter: r0 is the execute-stage ALU path, r1 is the multi-cycle/microcode path.
- The block picks one request per cycle by round-robin and drives the shifter's combinational inputs.
- It captures the shifter result and flags in a one-entry output register and returns them on a valid/ready response channel tagged with the requester ID.

Parameters:
- DW, 16, data width of shifter operand/result
- SW, 4, shift-amount width (log2 DW)
- FW, 3, shifter flag width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r0_valid  in  1  requester 0 has a shift request
- r0_ready  out  1  requester 0 request accepted this cycle
- r0_data  in  DW  requester 0 operand
- r0_amt  in  SW  requester 0 shift amount
- r0_mode  in  2  requester 0 mode: 00 SLL, 01 SRA, 10 ROR, 11 reserved
- r1_valid, r1_ready, r1_data, r1_amt, r1_mode  same as r0, for requester 1
- shf_in  out  DW  to shifter operand
- shf_val  out  SW  to shifter amount
- shf_mode  out  2  to shifter mode
- shf_out  in  DW  from shifter result (combinational)
- shf_flag  in  FW  from shifter flags (combinational)
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  DW  registered shift result
- rsp_flag  out  FW  registered shifter flags
- rsp_id  out  1  requester that issued the result (0/1)
- rsp_err  out  1  request used reserved mode 11

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_id=0, rsp_err=0.
  - Priority pointer = 0 (r0 favoured).
  - r0_ready=r1_ready=0 while rst is high.
  - Reset mid-transaction drops any held response; no request is considered accepted in that cycle.
- Slot free: slot_free = ~rsp_valid | rsp_ready.
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the requester pointed to by the priority pointer is granted.
  - Neither valid: no grant.
  - rX_ready = grant_X & slot_free & ~rst. At most one ready is high per cycle.
  - rX_ready depends combinationally on rX_valid. Requesters must not make valid depend on ready.
- Shifter drive:
  - shf_in/val/mode carry the granted requester's fields.
  - With no grant, they carry r0's fields (value is don't-care but must be deterministic, not X).
- Accept (rising edge with rX_valid & rX_ready):
  - rsp_data <= shf_out, rsp_flag <= shf_flag, rsp_id <= X, rsp_valid <= 1.
  - Priority pointer <= ~X, i.e. the other requester gets priority next.
- Reserved mode 11:
  - The request is accepted normally.
  - rsp_data <= operand unchanged, rsp_flag <= 0, rsp_err <= 1.
  - The shifter output is ignored.
- Drain: rsp_ready & rsp_valid with no new accept -> rsp_valid <= 0. rsp_data, rsp_flag, rsp_id and rsp_err hold their values.
- Simultaneous drain and accept: the register is overwritten with the new result and rsp_valid stays 1. This gives a throughput of one shift per cycle.
- Backpressure: rsp_valid=1 and rsp_ready=0 -> both readies are 0 and the response register holds stable. Requesters hold valid/data/amt/mode stable until accepted.
- Latency: accept at edge N -> rsp_valid high after edge N, i.e. visible in cycle N+1.
- Pointer: updates only on accept. An idle cycle does not rotate it.
- Amount 0: passes through in every mode, so result = operand.
- Amount width: amounts are SW bits only. Amount 15 is the maximum, and there is no wrap beyond DW-1.

Test Plan:
- r0 alone, data 0x1234, amt 4, mode 00, rsp_ready=1 -> rsp_valid next cycle, rsp_data 0x2340, rsp_id 0, rsp_err 0.
- r1 alone, data 0x1234, mode 10 (ROR) with amt 0/4/8/12 on consecutive cycles, rsp_ready=1 -> back-to-back results 0x1234, 0x4123, 0x3412, 0x2341, all with rsp_id 1.
- r0 and r1 both valid for 4 cycles (r0 0x8000 SRA 3, r1 0x00F0 SLL 1), rsp_ready=1 -> grants r0, r1, r0, r1; data alternates 0xF000 / 0x01E0.
- rsp_ready=0 after first accept, r0 valid -> r0_ready=0 and rsp_data held for 3 cycles; rsp_ready=1 -> drain and new accept on the same edge, rsp_valid stays 1.
- r0 mode 11, data 0xABCD -> rsp_data 0xABCD, rsp_err 1, rsp_flag 0; next normal request -> rsp_err 0.
- Assert rst for half a cycle while rsp_valid=1 and both requesters valid -> rsp_valid 0 immediately, readies 0; after release r0 granted first (pointer reset).
